// File: rtl/blift_share_sequencer.sv
// Feeds RNS shares to the base-lift sum-of-products engine through a 2-bank ping-pong buffer.
// Each collected result goes into a credit-guarded output FIFO and leaves in issue order.
module blift_share_sequencer #(
  parameter int NUM_SHARES = 7,
  parameter int SHARE_W    = 30,
  parameter int SOP_W      = 34,
  parameter int OUT_DEPTH  = 4,
  parameter int DRAIN_CYC  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SHARE_W-1:0] in_data,
  output logic               start,
  input  logic [2:0]         rd_addr,
  output logic [SHARE_W-1:0] a_shares,
  input  logic [SOP_W-1:0]   rounded_sop,
  input  logic               rounded_sop_write,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SOP_W-1:0]   out_data,
  output logic               busy,
  output logic               protocol_err
);
  localparam int PTR_W   = $clog2(OUT_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int SUM_W   = CNT_W + 1;
  localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [SHARE_W-1:0] bank_q [2][NUM_SHARES];
  logic [SHARE_W-1:0] bank_d [2][NUM_SHARES];
  logic [1:0]         full_q, full_d;
  logic               fill_ptr_q, fill_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [2:0]         wr_idx_q, wr_idx_d;
  logic [2:0]         burst_cnt_q, burst_cnt_d;
  logic               start_q, start_d;
  logic [SHARE_W-1:0] a_shares_q, a_shares_d;
  logic [CNT_W-1:0]   in_flight_q, in_flight_d;
  logic [SOP_W-1:0]   fifo_q [OUT_DEPTH];
  logic [SOP_W-1:0]   fifo_d [OUT_DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               err_q, err_d;

  logic drain_done, strobe, pop, push, fifo_full, in_ready_c, accept, fill_last;
  logic launch, dec, credit_ok, other_full, last_beat;
  logic [SUM_W-1:0] credit_sum;

  always_comb begin
    drain_done = (drain_q == '0);
    strobe     = rounded_sop_write && drain_done;
    pop        = (fifo_cnt_q != '0) && out_ready;
    fifo_full  = (fifo_cnt_q == CNT_W'(OUT_DEPTH));
    push       = strobe && (!fifo_full || pop);
    in_ready_c = drain_done && !full_q[fill_ptr_q];
    accept     = in_valid && in_ready_c;
    fill_last  = accept && (wr_idx_q == 3'(NUM_SHARES - 1));
    credit_sum = {1'b0, fifo_cnt_q} + {1'b0, in_flight_q};
    credit_ok  = credit_sum < SUM_W'(OUT_DEPTH);
    // A bank completing this very cycle counts as full so back-to-back bursts need no gap.
    other_full = full_q[~rd_ptr_q] || (fill_last && (fill_ptr_q != rd_ptr_q));
    last_beat  = (burst_cnt_q == 3'(NUM_SHARES - 1));

    bank_d     = bank_q;
    full_d     = full_q;
    fill_ptr_d = fill_ptr_q;
    wr_idx_d   = wr_idx_q;
    if (accept) begin
      bank_d[fill_ptr_q][wr_idx_q] = in_data;
      wr_idx_d = wr_idx_q + 3'd1;
      if (fill_last) begin
        full_d[fill_ptr_q] = 1'b1;
        fill_ptr_d = ~fill_ptr_q;
        wr_idx_d   = '0;
      end
    end

    state_d     = state_q;
    start_d     = start_q;
    burst_cnt_d = burst_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    launch      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (drain_done && full_q[rd_ptr_q] && credit_ok) begin
          state_d     = S_RUN;
          start_d     = 1'b1;
          burst_cnt_d = '0;
          launch      = 1'b1;
        end
      end
      S_RUN: begin
        burst_cnt_d = burst_cnt_q + 3'd1;
        if (last_beat) begin
          full_d[rd_ptr_q] = 1'b0;
          rd_ptr_d    = ~rd_ptr_q;
          burst_cnt_d = '0;
          if (other_full && credit_ok) begin
            launch = 1'b1;
          end else begin
            start_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    a_shares_d = (int'(rd_addr) < NUM_SHARES) ? bank_q[rd_ptr_q][rd_addr] : '0;

    dec = strobe && (in_flight_q != '0);
    in_flight_d = in_flight_q;
    if (launch && !dec)      in_flight_d = in_flight_q + CNT_W'(1);
    else if (!launch && dec) in_flight_d = in_flight_q - CNT_W'(1);

    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      fifo_d[wptr_q] = rounded_sop;
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (pop) rptr_d = rptr_q + PTR_W'(1);
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);

    err_d = err_q
          | (start_q && (burst_cnt_q != '0) && (rd_addr != burst_cnt_q))
          | (strobe && (in_flight_q == '0))
          | (strobe && fifo_full && !pop);

    drain_d = drain_done ? drain_q : drain_q - DRAIN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bank_q      <= '{default: '{default: '0}};
      full_q      <= '0;
      fill_ptr_q  <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_idx_q    <= '0;
      burst_cnt_q <= '0;
      start_q     <= 1'b0;
      a_shares_q  <= '0;
      in_flight_q <= '0;
      fifo_q      <= '{default: '0};
      wptr_q      <= '0;
      rptr_q      <= '0;
      fifo_cnt_q  <= '0;
      drain_q     <= DRAIN_W'(DRAIN_CYC);
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      full_q      <= full_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_idx_q    <= wr_idx_d;
      burst_cnt_q <= burst_cnt_d;
      start_q     <= start_d;
      a_shares_q  <= a_shares_d;
      in_flight_q <= in_flight_d;
      fifo_q      <= fifo_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      drain_q     <= drain_d;
      err_q       <= err_d;
    end
  end

  assign in_ready     = in_ready_c;
  assign start        = start_q;
  assign a_shares     = a_shares_q;
  assign out_valid    = (fifo_cnt_q != '0);
  assign out_data     = out_valid ? fifo_q[rptr_q] : '0;
  assign busy         = (|full_q) || (state_q == S_RUN) || (in_flight_q != '0);
  assign protocol_err = err_q;
endmodule

// File: tb/tb_blift_share_sequencer.sv
// Directed bench: share feeder, summing engine model and output monitor around the sequencer.
module tb_blift_share_sequencer;
  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [29:0] in_data = '0;
  logic        start;
  logic [2:0]  rd_addr = '0;
  logic [29:0] a_shares;
  logic [33:0] rounded_sop, eng_sop = '0;
  logic        rounded_sop_write, eng_wr = 1'b0, force_wr = 1'b0;
  logic        out_valid, out_ready = 1'b0, busy, protocol_err;
  logic [33:0] out_data;
  logic        skip_mode = 1'b0;

  assign rounded_sop_write = eng_wr | force_wr;
  assign rounded_sop       = force_wr ? 34'd3 : eng_sop;

  blift_share_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .start(start), .rd_addr(rd_addr), .a_shares(a_shares), .rounded_sop(rounded_sop),
    .rounded_sop_write(rounded_sop_write), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [29:0] feed_q [$];
  logic [33:0] rx_q [$];
  logic [29:0] ash_q [$];
  int          runs_q [$];
  int          start_cycles = 0;

  // Feeder: presents queued words, advances on handshake.
  logic acc_f;
  always begin
    @(negedge clk);
    acc_f = in_valid && in_ready;
    @(posedge clk); #1;
    if (acc_f && feed_q.size() > 0) void'(feed_q.pop_front());
    in_valid = (feed_q.size() != 0);
    in_data  = in_valid ? feed_q[0] : '0;
  end

  // Engine model (sums the seven shares) plus output/start monitors.
  int          run_len = 0, eng_cnt = 0;
  logic        prev_start = 1'b0, prev_last = 1'b0;
  logic [33:0] acc = '0;
  always @(negedge clk) begin
    eng_wr = 1'b0;
    if (!rst) begin
      acc = '0; eng_cnt = 0; prev_start = 1'b0; prev_last = 1'b0; run_len = 0; rd_addr = '0;
    end else begin
      if (out_valid && out_ready) rx_q.push_back(out_data);
      if (prev_start) begin
        ash_q.push_back(a_shares);
        acc = acc + 34'(a_shares);
        if (prev_last) begin
          eng_sop = acc; eng_wr = 1'b1; acc = '0;
        end
      end
      if (start) begin
        start_cycles++;
        run_len++;
        rd_addr   = (skip_mode && eng_cnt >= 3) ? 3'(eng_cnt + 1) : 3'(eng_cnt);
        prev_last = (eng_cnt == 6);
        eng_cnt   = prev_last ? 0 : eng_cnt + 1;
      end else begin
        if (run_len != 0) runs_q.push_back(run_len);
        run_len = 0; eng_cnt = 0; prev_last = 1'b0; rd_addr = '0;
      end
      prev_start = start;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_rx(int n, int budget, string nm);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin tick(); t++; end
    chk(nm, 64'(rx_q.size()), 64'(n));
  endtask

  task automatic wait_start(int budget, string nm);
    int t = 0;
    while (!start && t < budget) begin tick(); t++; end
    chk(nm, 64'(start), 64'd1);
  endtask

  task automatic push_coef(logic [6:0][29:0] sh);
    for (int k = 0; k < 7; k++) feed_q.push_back(sh[k]);
  endtask

  task automatic clear_mon();
    rx_q.delete(); ash_q.delete(); runs_q.delete(); start_cycles = 0;
  endtask

  function automatic logic [6:0][29:0] ramp(int base);
    logic [6:0][29:0] s;
    for (int k = 0; k < 7; k++) s[k] = 30'(base + k + 1);
    return s;
  endfunction

  function automatic logic [63:0] rx_at(int i);
    return (rx_q.size() > i) ? 64'(rx_q[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  typedef struct packed {
    logic [6:0][29:0] sh;
    logic [33:0]      exp_sop;
  } vec_t;

  initial begin
    vec_t vecs [4];
    int   early;
    for (int k = 0; k < 7; k++) begin
      vecs[0].sh[k] = 30'(k + 1);
      vecs[1].sh[k] = 30'(1000 * (k + 1));
      vecs[2].sh[k] = 30'h3FFF_FFFF;
      vecs[3].sh[k] = '0;
    end
    vecs[3].sh[0] = 30'h3FFF_FFFF;
    vecs[3].sh[6] = 30'd1;
    vecs[0].exp_sop = 34'd28;
    vecs[1].exp_sop = 34'd28000;
    vecs[2].exp_sop = 34'd7516192761;
    vecs[3].exp_sop = 34'd1073741824;

    rst = 1'b0;
    tick(3);
    chk("rst_start", start, 0);
    chk("rst_a_shares", a_shares, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_protocol_err", protocol_err, 0);

    rst = 1'b1;
    early = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      force_wr = (c == 5);
      if (in_ready) early++;
    end
    tick();
    force_wr = 1'b0;
    chk("drain_in_ready_early", 64'(early), 0);
    chk("drain_in_ready_c16", in_ready, 1);
    chk("drain_strobe_err", protocol_err, 0);
    chk("drain_strobe_out_valid", out_valid, 0);

    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      clear_mon();
      push_coef(vecs[v].sh);
      wait_rx(1, 80, "vec_rx_count");
      chk("vec_sop", rx_at(0), 64'(vecs[v].exp_sop));
      chk("vec_runs", 64'(runs_q.size()), 1);
      chk("vec_run_len", (runs_q.size() > 0) ? 64'(runs_q[0]) : 64'd0, 7);
      if (v == 0)
        for (int k = 0; k < 7; k++)
          chk("vec0_a_shares", (ash_q.size() > k) ? 64'(ash_q[k]) : 64'hFFFF, 64'(k + 1));
    end
    chk("vec_err", protocol_err, 0);

    clear_mon();
    for (int c = 1; c <= 3; c++) push_coef(ramp(c * 100));
    wait_rx(3, 200, "b2b_rx_count");
    chk("b2b_runs", 64'(runs_q.size()), 1);
    chk("b2b_run_len", (runs_q.size() > 0) ? 64'(runs_q[0]) : 64'd0, 21);
    chk("b2b_sop0", rx_at(0), 728);
    chk("b2b_sop1", rx_at(1), 1428);
    chk("b2b_sop2", rx_at(2), 2128);

    out_ready = 1'b0;
    tick();
    clear_mon();
    for (int c = 1; c <= 6; c++) push_coef(ramp(c * 1000));
    tick(150);
    chk("bp_start_cycles", 64'(start_cycles), 28);
    chk("bp_start", start, 0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_busy", busy, 1);
    chk("bp_rx_none", 64'(rx_q.size()), 0);
    out_ready = 1'b1;
    wait_rx(6, 300, "bp_rx_count");
    for (int i = 0; i < 6; i++) chk("bp_sop", rx_at(i), 64'(7000 * (i + 1) + 28));
    chk("bp_start_cycles_all", 64'(start_cycles), 42);
    chk("bp_err", protocol_err, 0);

    clear_mon();
    skip_mode = 1'b1;
    push_coef(ramp(0));
    wait_start(60, "skip_start_seen");
    tick(3);
    chk("skip_err_before", protocol_err, 0);
    tick();
    chk("skip_err_set", protocol_err, 1);
    tick(20);
    skip_mode = 1'b0;
    chk("skip_err_sticky", protocol_err, 1);
    rst = 1'b0;
    tick(2);
    chk("skip_err_cleared", protocol_err, 0);
    rst = 1'b1;
    tick(17);

    clear_mon();
    push_coef(ramp(0));
    wait_start(60, "abort_start_seen");
    tick(4);
    rst = 1'b0;
    tick();
    chk("abort_start", start, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      force_wr = (c == 3);
    end
    force_wr = 1'b0;
    chk("abort_stale_out_valid", out_valid, 0);
    chk("abort_stale_err", protocol_err, 0);
    chk("abort_stale_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);

    clear_mon();
    push_coef(ramp(0));
    wait_rx(1, 80, "recover_rx_count");
    chk("recover_sop", rx_at(0), 28);
    chk("recover_err", protocol_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
